seq_div_32_bit: RTL

SEQ_DIV_32_BIT -- requirements
Module: seq_div_32_bit

---
 rtl/seq_div_32_bit_pkg.sv | 14 +
 rtl/seq_div_32_bit_datapath.sv | 68 ++++++
 rtl/seq_div_32_bit.sv | 89 ++++++++
 3 files changed

// File: rtl/seq_div_32_bit_pkg.sv
// Shared definitions for the 32-bit sequential restoring divider:
// FSM state encodings, data width and iteration count.
package seq_div_32_bit_pkg;

  localparam int DATA_W     = 32;
  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_div_32_bit_datapath.sv
// Datapath for the restoring divider: operand, partial-remainder and quotient
// registers plus the 33-bit trial subtractor.
module seq_div_32_bit_datapath
  import seq_div_32_bit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic              sel_zero_i,
  input  logic              keep_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              sign_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  logic [DATA_W-1:0] dividend_q, dividend_d;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;

  // Shifted partial remainder with the next dividend bit, then the trial subtraction.
  always_comb begin
    shifted = {rem_q, dividend_q[DATA_W-1]};
    diff    = shifted - {1'b0, divisor_q};
    sign_o  = diff[DATA_W];
  end

  always_comb begin
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    if (load_i) begin
      dividend_d = a_i;
      divisor_d  = b_i;
      // A zero divisor short-circuits straight to the defined result.
      rem_d      = sel_zero_i ? a_i : '0;
      quot_d     = sel_zero_i ? '1 : '0;
    end else if (shift_i) begin
      dividend_d = {dividend_q[DATA_W-2:0], 1'b0};
      rem_d      = keep_i ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
      quot_d     = {quot_q[DATA_W-2:0], keep_i};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
    end else begin
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
    end
  end

  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/seq_div_32_bit.sv
// Top of the 32-bit unsigned sequential divider: control FSM producing
// registered status outputs and driving the datapath one quotient bit per cycle.
module seq_div_32_bit
  import seq_div_32_bit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] Quotient,
  output logic [DATA_W-1:0] Remainder
);

  state_t     state_q;
  logic [5:0] count_q;
  logic       busy_q, done_q, dbz_q;
  logic       load, shift, bZero, trialSign;

  assign bZero = (B == '0);
  assign load  = (state_q == IDLE) && start;
  assign shift = (state_q == RUN);

  seq_div_32_bit_datapath u_datapath (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .shift_i     (shift),
    .sel_zero_i  (bZero),
    .keep_i      (~trialSign),
    .a_i         (A),
    .b_i         (B),
    .sign_o      (trialSign),
    .quotient_o  (Quotient),
    .remainder_o (Remainder)
  );

  // start is only looked at in IDLE, so requests during RUN/DONE are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            count_q <= '0;
            dbz_q   <= bZero;
            if (bZero) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          count_q <= count_q + 6'd1;
          if (count_q == 6'(ITER_COUNT - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
